// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted,
    StFault
  } pc_state_t;

  localparam logic [31:0] PC_INCREMENT         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/adder.sv
// Plain 32-bit unsigned adder; carry-out is intentionally dropped (wraps).
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: valid/ready fetch issue, redirects, halt/resume and
// misaligned-target faults.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_inc;
  logic        handshake;
  logic        redir_aligned;
  logic        redir_misaligned;

  adder u_pc_adder (
    .a  (pc_q),
    .b  (PC_INCREMENT),
    .sum(pc_inc)
  );

  assign handshake        = fetch_valid & fetch_ready;
  assign redir_aligned    = redirect_valid & (redirect_target[1:0] == 2'b00);
  assign redir_misaligned = redirect_valid & (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // A handshake is always counted, even if a redirect discards its increment.
        if (handshake) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_inc;
        end
        if (redir_misaligned) begin
          state_d      = StFault;
          fault_addr_d = redirect_target;
          pc_d         = pc_q;
        end else begin
          if (redir_aligned) pc_d = redirect_target;
          if (halt_req) state_d = StHalted;
        end
      end
      StHalted: begin
        if (redir_misaligned) begin
          state_d      = StFault;
          fault_addr_d = redirect_target;
        end else begin
          if (redir_aligned) pc_d = redirect_target;
          if (resume_req && !halt_req) state_d = StRun;
        end
      end
      StFault: begin
        if (redir_misaligned) begin
          fault_addr_d = redirect_target;
        end else if (redir_aligned) begin
          pc_d    = redirect_target;
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= 32'h0;
      count_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign fetch_valid = (state_q == StRun);
  assign halted      = (state_q == StHalted);
  assign fault       = (state_q == StFault);
  assign fetch_pc    = pc_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume_req;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_1000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .halted         (halted),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        hlt;
    logic        res;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halted;
    logic        e_fault;
    logic [31:0] e_faddr;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] tgt, input logic hlt, input logic res,
                     input logic rdy, input logic e_valid, input logic [31:0] e_pc,
                     input logic e_halted, input logic e_fault, input logic [31:0] e_faddr,
                     input logic [31:0] e_count);
    vec_t v;
    v.rv = rv; v.tgt = tgt; v.hlt = hlt; v.res = res; v.rdy = rdy;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_halted = e_halted; v.e_fault = e_fault;
    v.e_faddr = e_faddr; v.e_count = e_count;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic e_valid, input logic [31:0] e_pc,
                       input logic e_halted, input logic e_fault, input logic [31:0] e_faddr,
                       input logic [31:0] e_count);
    n_cmp++;
    if (fetch_valid !== e_valid || fetch_pc !== e_pc || halted !== e_halted ||
        fault !== e_fault || fault_addr !== e_faddr || fetch_count !== e_count) begin
      n_bad++;
      $display("FAIL %s: got valid=%b pc=%h halted=%b fault=%b faddr=%h cnt=%0d ; want valid=%b pc=%h halted=%b fault=%b faddr=%h cnt=%0d",
               name, fetch_valid, fetch_pc, halted, fault, fault_addr, fetch_count,
               e_valid, e_pc, e_halted, e_fault, e_faddr, e_count);
    end
  endtask

  task automatic drive_idle();
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt_req        = 1'b0;
    resume_req      = 1'b0;
    fetch_ready     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    //   rv  target         h  r  rdy  valid pc            hlt flt faddr         cnt
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_1000, 0, 0, 32'h0,        0); // BOOT -> RUN
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_1004, 0, 0, 32'h0,        1);
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_1008, 0, 0, 32'h0,        2);
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_100C, 0, 0, 32'h0,        3);
    add(1, 32'h20,        0, 0, 0,   1, 32'h0000_0020, 0, 0, 32'h0,        3);
    for (int i = 0; i < 4; i++)
      add(0, 32'h0,       0, 0, 0,   1, 32'h0000_0020, 0, 0, 32'h0,        3); // stall
    add(1, 32'h40,        0, 0, 0,   1, 32'h0000_0040, 0, 0, 32'h0,        3);
    add(1, 32'h400,       0, 0, 1,   1, 32'h0000_0400, 0, 0, 32'h0,        4); // redirect+hs
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_0404, 0, 0, 32'h0,        5);
    add(1, 32'h402,       0, 0, 0,   0, 32'h0000_0404, 0, 1, 32'h402,      5); // misaligned
    add(0, 32'h0,         1, 1, 1,   0, 32'h0000_0404, 0, 1, 32'h402,      5); // ignored
    add(1, 32'h403,       0, 0, 0,   0, 32'h0000_0404, 0, 1, 32'h403,      5);
    add(1, 32'h500,       0, 0, 0,   1, 32'h0000_0500, 0, 0, 32'h403,      5); // clear
    add(1, 32'h80,        0, 0, 0,   1, 32'h0000_0080, 0, 0, 32'h403,      5);
    add(0, 32'h0,         1, 0, 1,   0, 32'h0000_0084, 1, 0, 32'h403,      6); // halt+hs
    add(1, 32'h200,       0, 0, 1,   0, 32'h0000_0200, 1, 0, 32'h403,      6);
    add(0, 32'h0,         1, 1, 1,   0, 32'h0000_0200, 1, 0, 32'h403,      6); // halt wins
    add(0, 32'h0,         0, 0, 1,   0, 32'h0000_0200, 1, 0, 32'h403,      6);
    add(0, 32'h0,         0, 1, 1,   1, 32'h0000_0200, 0, 0, 32'h403,      6); // resume
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_0204, 0, 0, 32'h403,      7);
    add(1, 32'hFFFF_FFFC, 0, 0, 0,   1, 32'hFFFF_FFFC, 0, 0, 32'h403,      7);
    add(0, 32'h0,         0, 0, 1,   1, 32'h0000_0000, 0, 0, 32'h403,      8); // pc wrap
    add(0, 32'h0,         1, 0, 0,   0, 32'h0000_0000, 1, 0, 32'h403,      8);
    add(1, 32'h1,         0, 0, 0,   0, 32'h0000_0000, 0, 1, 32'h1,        8); // fault from HALTED
    add(1, 32'h10,        0, 0, 0,   1, 32'h0000_0010, 0, 0, 32'h1,        8);
    add(0, 32'h0,         0, 0, 0,   1, 32'h0000_0010, 0, 0, 32'h1,        8);

    #12;
    check("reset_state", 0, 32'h0000_1000, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_no_valid", 0, 32'h0000_1000, 0, 0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      halt_req        = vecs[i].hlt;
      resume_req      = vecs[i].res;
      fetch_ready     = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_halted,
            vecs[i].e_fault, vecs[i].e_faddr, vecs[i].e_count);
    end

    // Asynchronous reset in the middle of a stalled fetch.
    drive_idle();
    @(posedge clk);
    #1;
    check("stall_before_reset", 1, 32'h0000_0010, 0, 0, 32'h1, 8);
    fetch_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 0, 32'h0000_1000, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    check("reset_held_drops_fetch", 0, 32'h0000_1000, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reboot_first_valid", 1, 32'h0000_1000, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    check("reboot_first_fetch", 1, 32'h0000_1004, 0, 0, 32'h0, 1);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
